// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared types and helpers for the serial pattern scan controller.
//   state_t  - controller FSM state (IDLE, LOAD, SHIFT, DONE)
//   BYTE_W   - width of the input byte stream
//   len_w()  - width needed to hold a pattern length of 0..pat_w
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial pattern matcher.
// Shifts one bit per enabled cycle into a history register, counts how many
// bits have arrived since the last restart (saturating at PAT_W), and
// compares the newest len bits against the pattern.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   bit_en       shift bit_in this cycle
//   bit_in       incoming serial bit
//   clr          clear history and bit count (start of a scan)
//   len          pattern length, already clamped to 0..PAT_W
//   pattern      pattern; bit [len-1] is the oldest bit of a match
//   overlap      0 = bit count restarts after each hit
//   hit          combinational: this cycle's bit completes a match
module seq_match_core
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = 8,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic             clr,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(PAT_W);

    // Only PAT_W-1 older bits need storing; the newest bit is bit_in itself.
    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] bits_seen;
    logic [LEN_W-1:0] bits_seen_next;

    always_comb begin
        hist_next      = {hist, bit_in};
        bits_seen_next = (bits_seen == SEEN_MAX) ? SEEN_MAX : bits_seen + 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        // len 0 never matches; bits_seen guards against stale history bits.
        hit = bit_en && (len != '0) && (bits_seen_next >= len)
              && (((hist_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (clr) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (bit_en) begin
            hist      <= hist_next[PAT_W-2:0];
            bits_seen <= (hit && !overlap) ? '0 : bits_seen_next;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: byte-stream serial pattern scan controller.
// Accepts bytes, serialises them one bit per clock into seq_match_core,
// counts matches and stops after a configured limit.
// Optional build macro: SEQ_SCAN_LSB_FIRST_EN -> bytes serialise LSB first
// (default MSB first).
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cfg_we                latch cfg_* (IDLE only)
//   cfg_pattern/len       pattern and its length (len > PAT_W clamps)
//   cfg_overlap           1 = overlapping matches
//   cfg_limit             stop after this many matches, 0 = unlimited
//   start                 begin a scan (IDLE only)
//   abort                 return to IDLE next cycle, no done pulse
//   in_valid/in_ready     byte handshake
//   in_byte               byte data
//   busy                  LOAD or SHIFT
//   match                 registered one-cycle match pulse
//   match_cnt             matches in the current/last scan
//   done                  high for the single DONE cycle
//   dbg_state             current FSM state
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in LOAD and does not depend on in_valid. An abort
// in the same cycle wins and the byte is not taken.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_limit,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(BYTE_W);

`ifdef SEQ_SCAN_LSB_FIRST_EN
    localparam logic [IDX_W-1:0] IDX_FIRST = '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_W - 1);
`else
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(BYTE_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = '0;
`endif

    state_t state, state_next;

    logic [PAT_W-1:0]  pat_r;
    logic [LEN_W-1:0]  len_r;
    logic              ovl_r;
    logic [CNT_W-1:0]  lim_r;
    logic [BYTE_W-1:0] byte_r;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  cnt_next;

    logic bit_en, clr, hit, stop, last_bit, accept;

    assign bit_en   = (state == SHIFT) && !abort;
    assign clr      = (state == IDLE) && start;
    assign accept   = (state == LOAD) && in_valid && !abort;
    assign last_bit = (bit_idx == IDX_LAST);
    assign cnt_next = match_cnt + 1'b1;
    // Counting wraps when unlimited; a nonzero limit stops on equality.
    assign stop     = (lim_r != '0) && (cnt_next == lim_r);

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .bit_en  (bit_en),
        .bit_in  (byte_r[bit_idx]),
        .clr     (clr),
        .len     (len_r),
        .pattern (pat_r),
        .overlap (ovl_r),
        .hit     (hit)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort outranks everything outside IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD: begin
                if (abort)         state_next = IDLE;
                else if (in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (abort)            state_next = IDLE;
                else if (hit && stop) state_next = DONE;
                else if (last_bit)    state_next = LOAD;
            end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state == LOAD) || (state == SHIFT);
        done      = (state == DONE);
        dbg_state = state;
    end

    // Config, byte buffer, bit index, match counter and pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r     <= '0;
            len_r     <= '0;
            ovl_r     <= 1'b0;
            lim_r     <= '0;
            byte_r    <= '0;
            bit_idx   <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
        end else begin
            if ((state == IDLE) && cfg_we) begin
                pat_r <= cfg_pattern;
                len_r <= (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
                ovl_r <= cfg_overlap;
                lim_r <= cfg_limit;
            end
            if (accept) begin
                byte_r  <= in_byte;
                bit_idx <= IDX_FIRST;
            end else if (bit_en) begin
`ifdef SEQ_SCAN_LSB_FIRST_EN
                bit_idx <= bit_idx + 1'b1;
`else
                bit_idx <= bit_idx - 1'b1;
`endif
            end
            if (clr)      match_cnt <= '0;
            else if (hit) match_cnt <= cnt_next;
            match <= hit;
        end
    end

endmodule
